// File: rtl/game_pkg.sv
// Shared types and constants for the game-flow controller.
// GAME_FLOW_PAUSE_EN adds the PAUSED state.
package game_pkg;

`ifdef GAME_FLOW_PAUSE_EN
  typedef enum logic [2:0] {
    WELCOME     = 3'd0,
    PLAY        = 3'd1,
    LEVEL_CLEAR = 3'd2,
    GAME_OVER   = 3'd3,
    PAUSED      = 3'd4
  } game_state_t;
`else
  typedef enum logic [1:0] {
    WELCOME     = 2'd0,
    PLAY        = 2'd1,
    LEVEL_CLEAR = 2'd2,
    GAME_OVER   = 2'd3
  } game_state_t;
`endif

  // Present type 0 is an extra life; type k feeds power-up channel k-1
  localparam int PT_LIFE        = 0;
  localparam int PU_IMMORTAL    = 0;
  localparam int PU_SUPER_ROPE  = 1;
  localparam int PU_SUPER_SPEED = 2;

  localparam int FRAME_W = 640;
  localparam int FRAME_H = 480;

endpackage

// File: rtl/powerup_timer.sv
// One power-up channel: load arms it for DURATION seconds, tick counts down
// unless hold is set, clear drops it immediately.
module powerup_timer #(
  parameter int DURATION = 5,
  parameter int TIMER_W  = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic load,
  input  logic tick,
  input  logic hold,
  output logic active
);

  logic [TIMER_W-1:0] timer;

  // The terminal tick at timer==0 is what finally drops the channel
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      active <= 1'b0;
      timer  <= '0;
    end else if (load) begin
      active <= 1'b1;
      timer  <= TIMER_W'(DURATION);
    end else if (tick && active && !hold) begin
      if (timer != '0) timer <= timer - 1'b1;
      else             active <= 1'b0;
    end
  end

endmodule

// File: rtl/game_flow_ctrl.sv
// Game-flow controller: state machine, lives, levels, game time, rope and
// power-up channels. Optional pause support under GAME_FLOW_PAUSE_EN.
module game_flow_ctrl
  import game_pkg::*;
#(
  parameter int INITIAL_LIVES  = 3,
  parameter int MAX_LIVES      = 7,
  parameter int LIVES_W        = 3,
  parameter int N_LEVELS       = 4,
  parameter int N_POWERUPS     = 3,
  parameter int PU_DURATION    = 5,
  parameter int PU_TIMER_W     = 3,
  parameter int PRESENT_PERIOD = 3,
  parameter int CLEAR_HOLD     = 2,
  localparam int PT_W          = $clog2(N_POWERUPS + 1),
  localparam int LEVEL_W       = $clog2(N_LEVELS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sec_tick,
  input  logic                  key_right,
  input  logic                  key_left,
  input  logic                  key_fire,
`ifdef GAME_FLOW_PAUSE_EN
  input  logic                  key_pause,
`endif
  input  logic                  col_player_ball,
  input  logic                  col_rope_ball,
  input  logic                  col_present,
  input  logic [PT_W-1:0]       present_type,
  input  logic                  balls_left_zero,
  input  logic [10:0]           player_x,
  input  logic [10:0]           rope_top_y,
  output logic [1:0]            game_state,
  output logic                  player_move_right,
  output logic                  player_move_left,
  output logic                  player_visible,
  output logic                  balls_visible,
  output logic                  rope_active,
  output logic [10:0]           rope_x,
  output logic                  present_drop,
  output logic                  player_reset,
  output logic                  level_start,
  output logic [LEVEL_W-1:0]    level,
  output logic [LIVES_W-1:0]    lives,
  output logic [11:0]           game_time,
  output logic [N_POWERUPS-1:0] powerup_active,
  output logic                  game_won
);

  localparam int SEC_W   = $clog2(PRESENT_PERIOD + 1);
  localparam int CLEAR_W = $clog2(CLEAR_HOLD + 1);

  game_state_t        state, next_state;
  logic               key_fire_d, fire_rise;
  logic               in_play, hit, extra;
  logic [LIVES_W-1:0] lives_nxt;
  logic [SEC_W-1:0]   sec_cnt;
  logic [CLEAR_W-1:0] clear_cnt;
  logic               pause_rise;

  assign fire_rise = key_fire & ~key_fire_d;
  assign in_play   = (state == PLAY);

`ifdef GAME_FLOW_PAUSE_EN
  logic key_pause_d;
  assign pause_rise = key_pause & ~key_pause_d;
  always_ff @(posedge clk) begin
    if (reset) key_pause_d <= 1'b0;
    else       key_pause_d <= key_pause;
  end
  assign game_state     = (state == PAUSED) ? 2'(PLAY) : state[1:0];
  assign player_visible = in_play || (state == PAUSED);
`else
  assign pause_rise     = 1'b0;
  assign game_state     = state;
  assign player_visible = in_play;
`endif

  assign balls_visible     = player_visible;
  assign player_move_right = in_play & key_right;
  assign player_move_left  = in_play & key_left;

  // A hit and an extra life in the same cycle cancel out
  always_comb begin
    next_state = state;
    hit        = 1'b0;
    extra      = 1'b0;
    lives_nxt  = lives;
    if (in_play) begin
      hit   = col_player_ball && !powerup_active[PU_IMMORTAL];
      extra = col_present && (present_type == PT_W'(PT_LIFE));
    end
    if (hit && !extra)
      lives_nxt = lives - 1'b1;
    else if (extra && !hit && (lives < LIVES_W'(MAX_LIVES)))
      lives_nxt = lives + 1'b1;
    case (state)
      WELCOME:     if (fire_rise) next_state = PLAY;
      PLAY: begin
        if (lives_nxt == '0)   next_state = GAME_OVER;
        else if (balls_left_zero) next_state = LEVEL_CLEAR;
`ifdef GAME_FLOW_PAUSE_EN
        else if (pause_rise)   next_state = PAUSED;
`endif
      end
      LEVEL_CLEAR:
        if (sec_tick && (clear_cnt == CLEAR_W'(CLEAR_HOLD - 1)))
          next_state = (level == LEVEL_W'(N_LEVELS - 1)) ? GAME_OVER : PLAY;
      GAME_OVER:   if (fire_rise) next_state = WELCOME;
`ifdef GAME_FLOW_PAUSE_EN
      PAUSED:      if (pause_rise) next_state = PLAY;
`endif
      default:     next_state = WELCOME;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= WELCOME;
    else       state <= next_state;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      key_fire_d   <= 1'b0;
      lives        <= LIVES_W'(INITIAL_LIVES);
      level        <= '0;
      game_time    <= '0;
      sec_cnt      <= '0;
      clear_cnt    <= '0;
      rope_active  <= 1'b0;
      rope_x       <= '0;
      game_won     <= 1'b0;
      present_drop <= 1'b0;
      player_reset <= 1'b0;
      level_start  <= 1'b0;
    end else begin
      key_fire_d   <= key_fire;
      present_drop <= 1'b0;
      player_reset <= 1'b0;
      level_start  <= 1'b0;
      case (state)
        WELCOME:
          if (fire_rise) begin
            lives        <= LIVES_W'(INITIAL_LIVES);
            level        <= '0;
            game_time    <= '0;
            sec_cnt      <= '0;
            game_won     <= 1'b0;
            level_start  <= 1'b1;
            player_reset <= 1'b1;
          end
        PLAY: begin
          lives     <= lives_nxt;
          clear_cnt <= '0;
          if (hit) player_reset <= 1'b1;
          if (sec_tick) begin
            game_time <= game_time + 12'd1;
            if (sec_cnt == SEC_W'(PRESENT_PERIOD - 1)) begin
              present_drop <= 1'b1;
              sec_cnt      <= '0;
            end else begin
              sec_cnt <= sec_cnt + 1'b1;
            end
          end
          // A rope/ball collision beats a fire press in the same cycle
          if (col_rope_ball)
            rope_active <= 1'b0;
          else if (fire_rise && !rope_active) begin
            rope_active <= 1'b1;
            rope_x      <= player_x;
          end else if (rope_active && (rope_top_y == '0) && !powerup_active[PU_SUPER_ROPE])
            rope_active <= 1'b0;
          if ((next_state == GAME_OVER) || (next_state == LEVEL_CLEAR))
            rope_active <= 1'b0;
          if (next_state == GAME_OVER)
            game_won <= 1'b0;
        end
        LEVEL_CLEAR:
          if (sec_tick) begin
            if (next_state == LEVEL_CLEAR) begin
              clear_cnt <= clear_cnt + 1'b1;
            end else begin
              clear_cnt <= '0;
              if (next_state == GAME_OVER) begin
                game_won <= 1'b1;
              end else begin
                level        <= level + 1'b1;
                level_start  <= 1'b1;
                player_reset <= 1'b1;
              end
            end
          end
        GAME_OVER: rope_active <= 1'b0;
        default: ;
      endcase
    end
  end

  // Channel timers only advance in PLAY, so pause and level-clear freeze them
  for (genvar k = 0; k < N_POWERUPS; k++) begin : g_pu
    logic load_k, clear_k, hold_k;
    assign load_k  = in_play && ((col_present && (present_type == PT_W'(k + 1))) ||
                                 ((k == PU_IMMORTAL) && hit));
    assign clear_k = (next_state == GAME_OVER) ||
                     ((k == PU_SUPER_ROPE) && in_play && col_rope_ball);
    assign hold_k  = (k == PU_SUPER_ROPE) && (rope_top_y != '0);

    powerup_timer #(
      .DURATION (PU_DURATION),
      .TIMER_W  (PU_TIMER_W)
    ) u_timer (
      .clk    (clk),
      .reset  (reset),
      .clear  (clear_k),
      .load   (load_k),
      .tick   (in_play && sec_tick),
      .hold   (hold_k),
      .active (powerup_active[k])
    );
  end

endmodule
